sw_arb_rr_5: RTL and testbench

- Output-port switch arbiter for the 5-port router.
- Shares one output port among the five input ports (L/N/E/S/W = 0..4) using round-robin priority.
- Packet-granular wormhole locking: a grant is held from head flit to tail flit.
- Drives the one-hot select of that output port's 5-way mux directly; one instance per output port.

---
 rtl/noc_arb_pkg.sv | 28 ++
 rtl/sw_arb_rr_5_if.sv | 23 ++
 rtl/rr_pick_5.sv | 22 ++
 rtl/sw_arb_rr_5.sv | 125 ++++++++++++
 tb/tb_sw_arb_rr_5.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_arb_pkg.sv
// Shared arbitration types for the 5-port router (L/N/E/S/W).
// Used by the switch arbiter and the VC allocator.
package noc_arb_pkg;

  localparam int PORT_NUM = 5;

  localparam logic [2:0] PORT_L = 3'd0;
  localparam logic [2:0] PORT_N = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_S = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;

  typedef logic [PORT_NUM-1:0] onehot5_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Port-index addition with wrap at 5; both operands are expected in 0..4.
  function automatic logic [2:0] mod5_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 4'd5) s = s - 4'd5;
    return s[2:0];
  endfunction

endpackage

// File: rtl/sw_arb_rr_5_if.sv
// Handshake bundle between the input-port side and one output-port switch arbiter.
interface sw_arb_rr_5_if;
  import noc_arb_pkg::*;

  logic [PORT_NUM-1:0] req_i;
  logic [PORT_NUM-1:0] tail_i;
  logic                out_ready_i;
  onehot5_t            grant_o;
  logic                xfer_o;
  logic                busy_o;
  logic                timeout_o;

  modport master (
    output req_i, tail_i, out_ready_i,
    input  grant_o, xfer_o, busy_o, timeout_o
  );

  modport slave (
    input  req_i, tail_i, out_ready_i,
    output grant_o, xfer_o, busy_o, timeout_o
  );

endinterface

// File: rtl/rr_pick_5.sv
// Combinational 5-way round-robin pick: first set req bit scanning from ptr, wrapping 4->0.
module rr_pick_5
  import noc_arb_pkg::*;
(
  input  onehot5_t   req_i,
  input  logic [2:0] ptr_i,
  output onehot5_t   winner_o
);

  logic [2:0] idx;

  always_comb begin
    winner_o = '0;
    idx      = '0;
    // lowest priority first, so the highest-priority hit is the last write
    for (int k = 4; k >= 0; k--) begin
      idx = mod5_add(ptr_i, 3'(k));
      if (req_i[idx]) winner_o = onehot5_t'(5'b00001 << idx);
    end
  end

endmodule

// File: rtl/sw_arb_rr_5.sv
// Output-port switch arbiter: round-robin with wormhole locking from head to tail flit.
// Optional idle-lock release enabled by defining SW_ARB_TIMEOUT_EN.
module sw_arb_rr_5
  import noc_arb_pkg::*;
#(
  parameter int PORT_NUM       = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  sw_arb_rr_5_if.slave  arb
);

  // state  | meaning
  // IDLE   | output port free, grant_o = 0
  // LOCKED | output port owned by one packet until its tail transfers

  if (PORT_NUM != 5) begin : g_bad_port_num
    $error("sw_arb_rr_5 supports PORT_NUM = 5 only");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sw_arb_rr_5 TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_t state_q;
  onehot5_t   grant_q;
  logic       busy_q;
  logic [2:0] ptr_q;

  logic [2:0] gidx;
  logic [2:0] pick_ptr;
  onehot5_t   pick_req;
  onehot5_t   winner;
  logic       xfer;
  logic       rel;
  logic       tmo_hit;

  always_comb begin
    gidx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (grant_q[i]) gidx = 3'(i);
    end
  end

  assign xfer = arb.out_ready_i & |(grant_q & arb.req_i);
  assign rel  = (state_q == LOCKED) & ((xfer & |(grant_q & arb.tail_i)) | tmo_hit);

  // In the release cycle the granted req bit still shows the outgoing tail, not a new packet.
  assign pick_req = rel ? (arb.req_i & ~grant_q) : arb.req_i;
  assign pick_ptr = rel ? mod5_add(gidx, 3'd1) : ptr_q;

  rr_pick_5 u_pick (
    .req_i    (pick_req),
    .ptr_i    (pick_ptr),
    .winner_o (winner)
  );

`ifdef SW_ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        timeout_q;
  logic        starved;

  assign starved = (state_q == LOCKED) & ~|(grant_q & arb.req_i);
  assign tmo_hit = starved & (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_hit;
      if (xfer || rel || state_q != LOCKED) cnt_q <= '0;
      else if (starved)                      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign arb.timeout_o = timeout_q;
`else
  assign tmo_hit       = 1'b0;
  assign arb.timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= PORT_L;
    end else begin
      case (state_q)
        IDLE: begin
          if (|arb.req_i) begin
            grant_q <= winner;
            state_q <= LOCKED;
            busy_q  <= 1'b1;
          end
        end
        LOCKED: begin
          if (rel) begin
            ptr_q <= pick_ptr;
            if (|pick_req) begin
              grant_q <= winner;
            end else begin
              grant_q <= '0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign arb.grant_o = grant_q;
  assign arb.busy_o  = busy_q;
  assign arb.xfer_o  = xfer;

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));

endmodule

// File: tb/tb_sw_arb_rr_5.sv
// Scoreboard bench for sw_arb_rr_5: per-cycle reference model plus directed checks.
module tb_sw_arb_rr_5;

  localparam int TO  = 8;
  localparam int PKT = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sw_arb_rr_5_if arb_if();

  sw_arb_rr_5 #(
    .PORT_NUM       (5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (arb_if)
  );

  typedef struct {
    logic [4:0] grant;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   m_g, m_ptr, m_cnt;
  int   rem[5];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_pick(input logic [4:0] v, input int p);
    for (int k = 0; k < 5; k++) begin
      if (v[(p + k) % 5]) return (p + k) % 5;
    end
    return -1;
  endfunction

  function automatic logic [4:0] tails();
    logic [4:0] t;
    for (int i = 0; i < 5; i++) t[i] = (rem[i] == 1);
    return t;
  endfunction

  function automatic int oh_idx(input logic [4:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 5; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_g   = -1;
    m_ptr = 0;
    m_cnt = 0;
    sb_q.delete();
    for (int i = 0; i < 5; i++) rem[i] = PKT;
  endtask

  // Called at posedge+1; drives inputs, checks xfer mid-cycle, checks registered outputs after the edge.
  task automatic step(input string tag, input logic [4:0] req, input logic [4:0] tail, input logic rdy);
    exp_t       e;
    logic       mx, tmo, rls;
    logic [4:0] pool;
    int         g0;
    arb_if.req_i       = req;
    arb_if.tail_i      = tail;
    arb_if.out_ready_i = rdy;
    #3;
    g0 = m_g;
    mx = 1'b0;
    if (g0 >= 0) mx = rdy && req[g0];
    chk({tag, "/xfer"}, 32'(arb_if.xfer_o), 32'(mx));
    tmo = 1'b0;
`ifdef SW_ARB_TIMEOUT_EN
    if (g0 >= 0) tmo = !req[g0] && (m_cnt == TO - 1);
`endif
    rls = 1'b0;
    if (g0 >= 0) rls = (mx && tail[g0]) || tmo;
    if (g0 < 0) begin
      m_g = ref_pick(req, m_ptr);
    end else if (rls) begin
      pool     = req;
      pool[g0] = 1'b0;
      m_ptr    = (g0 + 1) % 5;
      m_g      = ref_pick(pool, m_ptr);
    end
    if (g0 < 0 || mx || rls) m_cnt = 0;
    else if (!req[g0])       m_cnt++;
    if (mx) begin
      rem[g0]--;
      if (rem[g0] == 0) rem[g0] = PKT;
    end
    e.grant = (m_g < 0) ? 5'b0 : 5'(1 << m_g);
    e.busy  = (m_g >= 0);
    e.tmo   = tmo;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({tag, "/grant"},   32'(arb_if.grant_o),   32'(e.grant));
    chk({tag, "/busy"},    32'(arb_if.busy_o),    32'(e.busy));
    chk({tag, "/timeout"}, 32'(arb_if.timeout_o), 32'(e.tmo));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[$];
    int lens[$];
    int order[6];
    int last, runlen, gi, guard;

    order = '{0, 1, 2, 3, 4, 0};
    model_reset();
    rst                = 1'b1;
    arb_if.req_i       = '0;
    arb_if.tail_i      = '0;
    arb_if.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst/grant",   32'(arb_if.grant_o),   32'd0);
    chk("rst/busy",    32'(arb_if.busy_o),    32'd0);
    chk("rst/timeout", 32'(arb_if.timeout_o), 32'd0);
    chk("rst/ptr",     32'(dut.ptr_q),        32'd0);

    // single-flit packet on port 2
    step("t1_req", 5'b00100, 5'b00100, 1'b1);
    chk("t1_grant_lit", 32'(arb_if.grant_o), 32'h04);
    step("t1_xfer", 5'b00100, 5'b00100, 1'b1);
    chk("t1_release_grant", 32'(arb_if.grant_o), 32'd0);
    chk("t1_release_busy",  32'(arb_if.busy_o),  32'd0);
    chk("t1_ptr",           32'(dut.ptr_q),      32'd3);
    step("t1_idle", 5'b00000, 5'b00000, 1'b1);

    // async reset in the middle of a packet on port 2
    step("t5_head", 5'b00100, 5'b00000, 1'b1);
    step("t5_body", 5'b00100, 5'b00000, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_grant", 32'(arb_if.grant_o), 32'd0);
    chk("t5_async_busy",  32'(arb_if.busy_o),  32'd0);
    arb_if.req_i = '0;
    arb_if.tail_i = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t5_ptr", 32'(dut.ptr_q), 32'd0);

    // all ports busy with 3-flit packets
    last   = -1;
    runlen = 0;
    for (int c = 0; c < 17; c++) begin
      step("t2", 5'b11111, tails(), 1'b1);
      gi = oh_idx(arb_if.grant_o);
      if (c > 0) chk("t2_nogap", 32'(arb_if.grant_o != 5'b0), 32'd1);
      if (gi != last) begin
        if (last >= 0) lens.push_back(runlen);
        seq.push_back(gi);
        runlen = 1;
        last   = gi;
      end else begin
        runlen++;
      end
    end
    chk("t2_order_len", 32'(seq.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("t2_order%0d", k), 32'((k < seq.size()) ? seq[k] : -1), 32'(order[k]));
    for (int k = 0; k < 5; k++)
      chk($sformatf("t2_len%0d", k), 32'((k < lens.size()) ? lens[k] : -1), 32'(PKT));

    guard = 0;
    while (m_g >= 0 && guard < 10) begin
      step("drain", 5'(1 << m_g), tails() & 5'(1 << m_g), 1'b1);
      guard++;
    end
    if (m_g >= 0) chk("drain_bound", 32'd0, 32'd1);

    // wormhole bubble on port 1 while port 3 waits
    step("t3_head", 5'b00010, 5'b00000, 1'b1);
    step("t3_f1",   5'b00010, 5'b00000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step("t3_bubble", 5'b01000, 5'b00000, 1'b1);
      chk("t3_hold", 32'(arb_if.grant_o), 32'h02);
    end
    step("t3_f2",   5'b01010, 5'b00000, 1'b1);
    chk("t3_still_p1", 32'(arb_if.grant_o), 32'h02);
    step("t3_tail", 5'b01010, 5'b00010, 1'b1);
    chk("t3_p3_granted", 32'(arb_if.grant_o), 32'h08);
    step("t3_p3_tail", 5'b01000, 5'b01000, 1'b1);

    // backpressure with tail at head of port 4
    step("t4_req", 5'b10000, 5'b10000, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step("t4_stall", 5'b10000, 5'b10000, 1'b0);
      chk("t4_stall_grant", 32'(arb_if.grant_o), 32'h10);
    end
    step("t4_go", 5'b10000, 5'b10000, 1'b1);
    chk("t4_release", 32'(arb_if.grant_o), 32'd0);

    // granted port 0 goes silent while port 2 waits
    step("t6_head", 5'b00001, 5'b00000, 1'b1);
    step("t6_body", 5'b00001, 5'b00000, 1'b1);
`ifdef SW_ARB_TIMEOUT_EN
    for (int k = 1; k <= TO; k++) begin
      step("t6_silent", 5'b00100, 5'b00000, 1'b1);
      if (k < TO) begin
        chk("t6_hold",     32'(arb_if.grant_o),   32'h01);
        chk("t6_nopulse",  32'(arb_if.timeout_o), 32'd0);
      end else begin
        chk("t6_pulse",    32'(arb_if.timeout_o), 32'd1);
        chk("t6_regrant",  32'(arb_if.grant_o),   32'h04);
      end
    end
    step("t6_after", 5'b00100, 5'b00000, 1'b1);
    chk("t6_pulse_end", 32'(arb_if.timeout_o), 32'd0);
`else
    for (int k = 0; k < 12; k++) begin
      step("t6_silent", 5'b00100, 5'b00000, 1'b1);
      chk("t6_hold",    32'(arb_if.grant_o),   32'h01);
      chk("t6_nopulse", 32'(arb_if.timeout_o), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
